lock_sequencer: RTL and testbench

- Controller for the DE1-SoC combination lock: sequences 4-bit digit entries and compares them against a stored 6-digit code.
- Counts failed attempts, enforces a timed lockout, and supports reprogramming the code while open.
- Sits between the debounced switch/key front end and the HEX/LEDR display decoders.

---
 rtl/lock_pkg.sv | 23 ++
 rtl/lockout_timer.sv | 29 ++
 rtl/lock_sequencer.sv | 163 ++++++++++++++++
 tb/tb_lock_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared constants for the combination-lock controller: code geometry,
// state encoding and the digit-extraction helper.
package lock_pkg;

  localparam int DIGITS  = 6;
  localparam int DIGIT_W = 4;
  localparam int CODE_W  = DIGITS * DIGIT_W;
  localparam int STATE_W = 3;
  localparam int COUNT_W = 3;
  localparam int FAIL_W  = 2;

  localparam logic [STATE_W-1:0] ST_ENTRY   = 3'd0;
  localparam logic [STATE_W-1:0] ST_OPEN    = 3'd1;
  localparam logic [STATE_W-1:0] ST_FAIL    = 3'd2;
  localparam logic [STATE_W-1:0] ST_LOCKOUT = 3'd3;
  localparam logic [STATE_W-1:0] ST_PROG    = 3'd4;

  function automatic logic [DIGIT_W-1:0] code_digit(input logic [CODE_W-1:0] code,
                                                    input logic [COUNT_W-1:0] idx);
    return code[int'(idx) * DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// Down-counter holding the lock in LOCKOUT; done is high during the final
// counted cycle so the FSM leaves exactly LOAD_VALUE cycles after loading.
module lockout_timer #(
  parameter int LOAD_VALUE = 16,
  parameter int W          = $clog2(LOAD_VALUE + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= W'(LOAD_VALUE);
    end else if (en && count != '0) begin
      // NOTE: state updates use <= so every flop samples pre-edge values.
      count <= count - 1'b1;
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/lock_sequencer.sv
// Combination-lock FSM: collects digit entries, checks them against the stored
// code, tracks failed attempts, runs the lockout and reprograms the code.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int                MAX_FAILS      = 3,
  parameter int                LOCKOUT_CYCLES = 16,
  parameter logic [CODE_W-1:0] DEFAULT_CODE   = 24'h654321
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               relock,
  input  logic               prog_req,
  output logic [STATE_W-1:0] state_code,
  output logic               open,
  output logic               error,
  output logic               locked_out,
  output logic [COUNT_W-1:0] digit_count,
  output logic [FAIL_W-1:0]  fail_count
);

  localparam logic [COUNT_W-1:0] LAST_IDX  = COUNT_W'(DIGITS - 1);
  localparam logic [FAIL_W-1:0]  FAIL_LIM  = FAIL_W'(MAX_FAILS);

  logic [STATE_W-1:0] state_q, state_d;
  logic [COUNT_W-1:0] dc_q, dc_d;
  logic [FAIL_W-1:0]  fc_q, fc_d, fc_inc;
  logic               mm_q, mm_d, miss;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [CODE_W-1:0]  shadow_q, shadow_d;
  logic               timer_load, timer_en, timer_done;

  lockout_timer #(
    .LOAD_VALUE(LOCKOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .en    (timer_en),
    .done  (timer_done)
  );

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves a latch.
    state_d    = state_q;
    dc_d       = dc_q;
    fc_d       = fc_q;
    mm_d       = mm_q;
    code_d     = code_q;
    shadow_d   = shadow_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    miss       = (digit != code_digit(code_q, dc_q));
    fc_inc     = (fc_q == FAIL_LIM) ? fc_q : fc_q + 1'b1;

    case (state_q)
      // A digit in FAIL starts a new attempt; digit_count and mismatch are
      // already clear, so it is handled exactly like an ENTRY digit.
      ST_ENTRY, ST_FAIL: begin
        if (relock) begin
          state_d = ST_ENTRY;
          dc_d    = '0;
          mm_d    = 1'b0;
        end else if (digit_valid) begin
          state_d = ST_ENTRY;
          if (dc_q == LAST_IDX) begin
            dc_d = '0;
            mm_d = 1'b0;
            if (!(mm_q || miss)) begin
              state_d = ST_OPEN;
              fc_d    = '0;
            end else begin
              fc_d = fc_inc;
              if (fc_inc == FAIL_LIM) begin
                state_d    = ST_LOCKOUT;
                timer_load = 1'b1;
              end else begin
                state_d = ST_FAIL;
              end
            end
          end else begin
            dc_d = dc_q + 1'b1;
            mm_d = mm_q | miss;
          end
        end
      end

      ST_LOCKOUT: begin
        timer_en = 1'b1;
        if (timer_done) begin
          state_d = ST_ENTRY;
          fc_d    = '0;
        end
      end

      ST_OPEN: begin
        if (relock) begin
          state_d = ST_ENTRY;
        end else if (prog_req) begin
          state_d = ST_PROG;
          dc_d    = '0;
        end
      end

      ST_PROG: begin
        if (relock) begin
          state_d = ST_ENTRY;
          dc_d    = '0;
        end else if (digit_valid) begin
          shadow_d[int'(dc_q) * DIGIT_W +: DIGIT_W] = digit;
          if (dc_q == LAST_IDX) begin
            code_d  = shadow_d;
            state_d = ST_OPEN;
            dc_d    = '0;
          end else begin
            dc_d = dc_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_ENTRY;
        dc_d    = '0;
        mm_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ENTRY;
      dc_q       <= '0;
      fc_q       <= '0;
      mm_q       <= 1'b0;
      code_q     <= DEFAULT_CODE;
      open       <= 1'b0;
      error      <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state_q    <= state_d;
      dc_q       <= dc_d;
      fc_q       <= fc_d;
      mm_q       <= mm_d;
      code_q     <= code_d;
      open       <= (state_d == ST_OPEN);
      error      <= (state_d == ST_FAIL);
      locked_out <= (state_d == ST_LOCKOUT);
    end
  end

  // NOTE: shadow is fully rewritten before it is ever copied into the code,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign state_code  = state_q;
  assign digit_count = dc_q;
  assign fail_count  = fc_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: directed vector table, hand-written
// corner sequences and randomized stimulus against a queue-based reference.
module tb_lock_sequencer;

  localparam int MAX_FAILS = 3;
  localparam int LOCK_CYC  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = '0;
  logic       relock = 1'b0;
  logic       prog_req = 1'b0;
  logic [2:0] state_code;
  logic       open, error, locked_out;
  logic [2:0] digit_count;
  logic [1:0] fail_count;

  int checks = 0;
  int failures = 0;

  lock_sequencer #(
    .MAX_FAILS      (MAX_FAILS),
    .LOCKOUT_CYCLES (LOCK_CYC),
    .DEFAULT_CODE   (24'h654321)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digit_valid (digit_valid),
    .digit       (digit),
    .relock      (relock),
    .prog_req    (prog_req),
    .state_code  (state_code),
    .open        (open),
    .error       (error),
    .locked_out  (locked_out),
    .digit_count (digit_count),
    .fail_count  (fail_count)
  );

  always #5 clk = ~clk;

  // Reference model: state number, entered digits as a queue, whole-code compare.
  int m_st;
  int m_fails;
  int m_left;
  int m_code[6];
  int m_entry[$];

  function automatic void model_reset();
    m_st = 0; m_fails = 0; m_left = 0;
    for (int i = 0; i < 6; i++) m_code[i] = i + 1;
    m_entry.delete();
  endfunction

  function automatic void model_step(input bit dv, input int d, input bit rl, input bit pr);
    bit ok;
    case (m_st)
      0, 2: begin
        if (rl) begin
          m_entry.delete(); m_st = 0;
        end else if (dv) begin
          m_st = 0;
          m_entry.push_back(d);
          if (m_entry.size() == 6) begin
            ok = 1;
            for (int i = 0; i < 6; i++) if (m_entry[i] != m_code[i]) ok = 0;
            m_entry.delete();
            if (ok) begin
              m_st = 1; m_fails = 0;
            end else begin
              m_fails = (m_fails + 1 > MAX_FAILS) ? MAX_FAILS : m_fails + 1;
              if (m_fails == MAX_FAILS) begin
                m_st = 3; m_left = LOCK_CYC;
              end else begin
                m_st = 2;
              end
            end
          end
        end
      end
      3: begin
        m_left--;
        if (m_left == 0) begin m_st = 0; m_fails = 0; end
      end
      1: begin
        if (rl) m_st = 0;
        else if (pr) begin m_st = 4; m_entry.delete(); end
      end
      4: begin
        if (rl) begin
          m_st = 0; m_entry.delete();
        end else if (dv) begin
          m_entry.push_back(d);
          if (m_entry.size() == 6) begin
            for (int i = 0; i < 6; i++) m_code[i] = m_entry[i];
            m_entry.delete();
            m_st = 1;
          end
        end
      end
      default: m_st = 0;
    endcase
  endfunction

  function automatic logic [10:0] exp_vec(input int st, input int dc, input int fc);
    return {3'(st), 1'(st == 1), 1'(st == 2), 1'(st == 3), 3'(dc), 2'(fc)};
  endfunction

  function automatic logic [10:0] model_exp();
    return exp_vec(m_st, m_entry.size(), m_fails);
  endfunction

  function automatic logic [10:0] out_vec();
    return {state_code, open, error, locked_out, digit_count, fail_count};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then sample #1 after the edge.
  task automatic step(input bit dv, input int d, input bit rl, input bit pr);
    digit_valid = dv; digit = 4'(d); relock = rl; prog_req = pr;
    @(posedge clk);
    #1;
    digit_valid = 1'b0; relock = 1'b0; prog_req = 1'b0;
    model_step(dv, d, rl, pr);
  endtask

  task automatic enter(input int a, input int b, input int c,
                       input int d, input int e, input int f);
    step(1, a, 0, 0); step(1, b, 0, 0); step(1, c, 0, 0);
    step(1, d, 0, 0); step(1, e, 0, 0); step(1, f, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #3;
    check("reset_state", 32'(out_vec()), 32'(exp_vec(0, 0, 0)));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit dv; int d; bit rl; bit pr;
    int st; int dc; int fc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input bit dv, input int d, input bit rl, input bit pr,
                             input int st, input int dc, input int fc);
    vec_t r;
    r.dv = dv; r.d = d; r.rl = rl; r.pr = pr; r.st = st; r.dc = dc; r.fc = fc;
    return r;
  endfunction

  initial begin
    int n;
    bit dv, rl, pr;
    int d;

    // Correct code, relock, wrong code, restart from FAIL, relock with digit,
    // ignored prog_req, correct code, ignored digit in OPEN, relock beats prog_req.
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(1, 2, 0, 0, 0, 2, 0));
    vecs.push_back(v(1, 3, 0, 0, 0, 3, 0));
    vecs.push_back(v(1, 4, 0, 0, 0, 4, 0));
    vecs.push_back(v(1, 5, 0, 0, 0, 5, 0));
    vecs.push_back(v(1, 6, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(1, 2, 0, 0, 0, 2, 0));
    vecs.push_back(v(1, 3, 0, 0, 0, 3, 0));
    vecs.push_back(v(1, 4, 0, 0, 0, 4, 0));
    vecs.push_back(v(1, 5, 0, 0, 0, 5, 0));
    vecs.push_back(v(1, 7, 0, 0, 2, 0, 1));
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(v(1, 2, 0, 0, 0, 2, 1));
    vecs.push_back(v(1, 3, 0, 0, 0, 3, 1));
    vecs.push_back(v(1, 9, 1, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(v(1, 2, 0, 0, 0, 2, 1));
    vecs.push_back(v(1, 3, 0, 0, 0, 3, 1));
    vecs.push_back(v(1, 4, 0, 0, 0, 4, 1));
    vecs.push_back(v(1, 5, 0, 0, 0, 5, 1));
    vecs.push_back(v(1, 6, 0, 0, 1, 0, 0));
    vecs.push_back(v(1, 5, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 0, 0));

    do_reset();
    foreach (vecs[i]) begin
      step(vecs[i].dv, vecs[i].d, vecs[i].rl, vecs[i].pr);
      check($sformatf("vec%0d", i), 32'(out_vec()),
            32'(exp_vec(vecs[i].st, vecs[i].dc, vecs[i].fc)));
    end

    // Three wrong attempts -> lockout of exactly LOCK_CYC cycles, inputs ignored.
    do_reset();
    repeat (3) enter(0, 0, 0, 0, 0, 0);
    check("lock_enter", 32'(out_vec()), 32'(exp_vec(3, 0, 3)));
    n = 0;
    while (locked_out && n < 100) begin
      n++;
      step(1, $urandom_range(0, 15), (n % 5) == 0, (n % 3) == 0);
      check("lock_model", 32'(out_vec()), 32'(model_exp()));
    end
    check("lock_len", 32'(n), 32'(LOCK_CYC));
    check("lock_exit", 32'(out_vec()), 32'(exp_vec(0, 0, 0)));
    enter(1, 2, 3, 4, 5, 6);
    check("open_after_lock", 32'(out_vec()), 32'(exp_vec(1, 0, 0)));

    // Reprogram to 9,8,7,6,5,4.
    step(0, 0, 0, 1);
    check("prog_enter", 32'(out_vec()), 32'(exp_vec(4, 0, 0)));
    enter(9, 8, 7, 6, 5, 4);
    check("prog_done", 32'(out_vec()), 32'(exp_vec(1, 0, 0)));
    step(0, 0, 1, 0);
    enter(1, 2, 3, 4, 5, 6);
    check("old_code_rejected", 32'(out_vec()), 32'(exp_vec(2, 0, 1)));
    step(0, 0, 1, 0);
    enter(9, 8, 7, 6, 5, 4);
    check("new_code_opens", 32'(out_vec()), 32'(exp_vec(1, 0, 0)));

    // Aborted reprogramming keeps the code.
    step(0, 0, 0, 1);
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    check("prog_abort", 32'(out_vec()), 32'(exp_vec(0, 0, 0)));
    enter(9, 8, 7, 6, 5, 4);
    check("code_kept", 32'(out_vec()), 32'(exp_vec(1, 0, 0)));
    step(0, 0, 1, 0);

    // Asynchronous reset in the middle of a lockout.
    repeat (3) enter(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    check("pre_reset_locked", 32'(out_vec()), 32'(exp_vec(3, 0, 3)));
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 32'(out_vec()), 32'(exp_vec(0, 0, 0)));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    enter(1, 2, 3, 4, 5, 6);
    check("default_code_back", 32'(out_vec()), 32'(exp_vec(1, 0, 0)));

    // Randomized traffic against the reference model.
    do_reset();
    repeat (3000) begin
      dv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0 && m_entry.size() < 6)
        d = m_code[m_entry.size()];
      else
        d = $urandom_range(0, 15);
      rl = ($urandom_range(0, 15) == 0);
      pr = ($urandom_range(0, 7) == 0);
      step(dv, d, rl, pr);
      check("random", 32'(out_vec()), 32'(model_exp()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
